// File: rtl/pc_pkg.sv
// Shared types and default widths for the program-counter sequencer.
package pc_pkg;

  localparam int unsigned PC_W_DEF        = 12;
  localparam int unsigned OFF_W_DEF       = 8;
  localparam int unsigned STACK_DEPTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } pc_state_t;

  typedef enum logic [2:0] {
    SEL_HOLD,
    SEL_SEQ,
    SEL_BR,
    SEL_ABS,
    SEL_CALL,
    SEL_RET
  } pc_sel_t;

endpackage

// File: rtl/pc_return_stack.sv
// Hardware return-address stack: only the stack pointer is reset, storage is not.
module pc_return_stack #(
  parameter int unsigned PC_W        = 12,
  parameter int unsigned STACK_DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset_n,
  input  logic            clear,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] push_data,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty
);

  localparam int unsigned SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [SP_W-1:0]  sp;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [PC_W-1:0]  mem [0:(1 << IDX_W)-1];

  // rd_idx wraps to the last slot when sp==STACK_DEPTH is a power of two
  assign wr_idx = sp[IDX_W-1:0];
  assign rd_idx = wr_idx - IDX_W'(1);
  assign full   = (sp == SP_W'(STACK_DEPTH));
  assign empty  = (sp == '0);
  assign top    = mem[rd_idx];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sp <= '0;
    end else if (clear) begin
      sp <= '0;
    end else if (push && !full) begin
      sp <= sp + SP_W'(1);
    end else if (pop && !empty) begin
      sp <= sp - SP_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (push && !full && !clear) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: start/run/done control, branches, jumps and call/return.
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned PC_W        = PC_W_DEF,
  parameter int unsigned OFF_W       = OFF_W_DEF,
  parameter int unsigned STACK_DEPTH = STACK_DEPTH_DEF
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             start,
  input  logic [PC_W-1:0]  start_addr,
  input  logic [PC_W-1:0]  done_addr,
  input  logic             advance,
  input  logic             branch_taken,
  input  logic [OFF_W-1:0] branch_offset,
  input  logic             jump_abs,
  input  logic             call,
  input  logic             ret,
  input  logic [PC_W-1:0]  jump_target,
  output logic [PC_W-1:0]  pc_out,
  output logic             busy,
  output logic             done,
  output logic             stack_err
);

  pc_state_t       state, next_state;
  pc_sel_t         sel;
  logic            push, pop, fault;
  logic            full, empty;
  logic [PC_W-1:0] top;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] off_ext;
  logic [PC_W-1:0] pc_next;

  assign pc_inc  = pc_out + PC_W'(1);
  assign off_ext = {{(PC_W-OFF_W){branch_offset[OFF_W-1]}}, branch_offset};

  pc_return_stack #(
    .PC_W        (PC_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clock     (clock),
    .reset_n   (reset_n),
    .clear     (start),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top       (top),
    .full      (full),
    .empty     (empty)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Reaching done_addr outranks any request presented in the same cycle
  always_comb begin
    next_state = state;
    sel        = SEL_HOLD;
    push       = 1'b0;
    pop        = 1'b0;
    fault      = 1'b0;
    if (start) begin
      next_state = RUN;
    end else begin
      case (state)
        RUN: begin
          if (pc_out == done_addr) begin
            next_state = DONE;
          end else if (advance) begin
            if (ret) begin
              if (empty) fault = 1'b1;
              else begin
                sel = SEL_RET;
                pop = 1'b1;
              end
            end else if (call) begin
              if (full) fault = 1'b1;
              else begin
                sel  = SEL_CALL;
                push = 1'b1;
              end
            end else if (jump_abs) begin
              sel = SEL_ABS;
            end else if (branch_taken) begin
              sel = SEL_BR;
            end else begin
              sel = SEL_SEQ;
            end
            if (fault) next_state = DONE;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    pc_next = pc_out;
    case (sel)
      SEL_SEQ:            pc_next = pc_inc;
      SEL_BR:             pc_next = pc_inc + off_ext;
      SEL_ABS, SEL_CALL:  pc_next = jump_target;
      SEL_RET:            pc_next = top;
      default:            pc_next = pc_out;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc_out    <= '0;
      stack_err <= 1'b0;
    end else if (start) begin
      pc_out    <= start_addr;
      stack_err <= 1'b0;
    end else begin
      pc_out <= pc_next;
      if (fault) stack_err <= 1'b1;
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus queues expected outputs, a monitor compares each cycle.
module tb_pc_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [11:0] start_addr;
  logic [11:0] done_addr;
  logic        advance;
  logic        branch_taken;
  logic [7:0]  branch_offset;
  logic        jump_abs;
  logic        call;
  logic        ret;
  logic [11:0] jump_target;
  logic [11:0] pc_out;
  logic        busy;
  logic        done;
  logic        stack_err;

  typedef struct {
    string       name;
    logic [11:0] pc;
    logic        busy;
    logic        done;
    logic        err;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  pc_sequencer #(
    .PC_W        (12),
    .OFF_W       (8),
    .STACK_DEPTH (4)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .start         (start),
    .start_addr    (start_addr),
    .done_addr     (done_addr),
    .advance       (advance),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump_abs      (jump_abs),
    .call          (call),
    .ret           (ret),
    .jump_target   (jump_target),
    .pc_out        (pc_out),
    .busy          (busy),
    .done          (done),
    .stack_err     (stack_err)
  );

  // Monitor: one expectation consumed per clock, sampled just after the edge
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        checks++;
        if (pc_out !== e.pc || busy !== e.busy || done !== e.done || stack_err !== e.err) begin
          errors++;
          $display("FAIL %s: got pc=%03h busy=%b done=%b err=%b, want pc=%03h busy=%b done=%b err=%b",
                   e.name, pc_out, busy, done, stack_err, e.pc, e.busy, e.done, e.err);
        end
      end
    end
  end

  task automatic expect_cycle(input string name, input logic [11:0] pc,
                              input logic b, input logic d, input logic e);
    exp_t x;
    x.name = name; x.pc = pc; x.busy = b; x.done = d; x.err = e;
    q.push_back(x);
    @(negedge clock);
  endtask

  task automatic clear_req();
    start = 0; advance = 0; branch_taken = 0; jump_abs = 0; call = 0; ret = 0;
  endtask

  initial begin
    reset_n = 0; clear_req();
    start_addr = '0; done_addr = '0; branch_offset = '0; jump_target = '0;
    @(negedge clock);
    expect_cycle("reset", 12'h000, 0, 0, 0);
    reset_n = 1;
    advance = 1;
    expect_cycle("idle_ignores_adv", 12'h000, 0, 0, 0);

    start = 1; start_addr = 12'h010; done_addr = 12'h100; advance = 0;
    expect_cycle("start", 12'h010, 1, 0, 0);
    start = 0; advance = 1;
    expect_cycle("seq1", 12'h011, 1, 0, 0);
    expect_cycle("seq2", 12'h012, 1, 0, 0);
    expect_cycle("seq3", 12'h013, 1, 0, 0);
    advance = 0; branch_taken = 1; jump_abs = 1; jump_target = 12'h555;
    expect_cycle("hold_no_adv", 12'h013, 1, 0, 0);

    clear_req(); advance = 1; jump_abs = 1; jump_target = 12'h020;
    expect_cycle("jabs_020", 12'h020, 1, 0, 0);
    jump_abs = 0; branch_taken = 1; branch_offset = 8'hFC;
    expect_cycle("br_neg", 12'h01D, 1, 0, 0);
    branch_taken = 0; jump_abs = 1; jump_target = 12'h020;
    expect_cycle("jabs_020b", 12'h020, 1, 0, 0);
    jump_abs = 0; branch_taken = 1; branch_offset = 8'h05;
    expect_cycle("br_pos", 12'h026, 1, 0, 0);

    branch_taken = 0; jump_abs = 1; jump_target = 12'hFFF;
    expect_cycle("jabs_fff", 12'hFFF, 1, 0, 0);
    jump_abs = 0;
    expect_cycle("wrap", 12'h000, 1, 0, 0);

    call = 1; jump_target = 12'h200;
    expect_cycle("call_from_0", 12'h200, 1, 0, 0);
    call = 1; ret = 1; branch_taken = 1; branch_offset = 8'h10; jump_target = 12'h300;
    expect_cycle("ret_priority", 12'h001, 1, 0, 0);

    clear_req(); advance = 1; jump_abs = 1; jump_target = 12'h030;
    expect_cycle("jabs_030", 12'h030, 1, 0, 0);
    jump_abs = 0; call = 1; jump_target = 12'h200;
    expect_cycle("call_200", 12'h200, 1, 0, 0);
    call = 0; ret = 1;
    expect_cycle("ret_031", 12'h031, 1, 0, 0);

    ret = 0; call = 1;
    jump_target = 12'h040; expect_cycle("call1", 12'h040, 1, 0, 0);
    jump_target = 12'h050; expect_cycle("call2", 12'h050, 1, 0, 0);
    jump_target = 12'h060; expect_cycle("call3", 12'h060, 1, 0, 0);
    jump_target = 12'h070; expect_cycle("call4", 12'h070, 1, 0, 0);
    call = 0; ret = 1;
    expect_cycle("ret_061", 12'h061, 1, 0, 0);
    ret = 0; call = 1; jump_target = 12'h070;
    expect_cycle("call4b", 12'h070, 1, 0, 0);
    jump_target = 12'h080;
    expect_cycle("overflow", 12'h070, 0, 1, 1);
    expect_cycle("done_holds", 12'h070, 0, 1, 1);

    clear_req(); start = 1; start_addr = 12'h050;
    expect_cycle("restart_clr_err", 12'h050, 1, 0, 0);
    start = 0; advance = 1; ret = 1;
    expect_cycle("underflow", 12'h050, 0, 1, 1);

    clear_req(); start = 1; start_addr = 12'h010; done_addr = 12'h015;
    expect_cycle("start_010", 12'h010, 1, 0, 0);
    start = 0; advance = 1;
    expect_cycle("run_011", 12'h011, 1, 0, 0);
    expect_cycle("run_012", 12'h012, 1, 0, 0);
    expect_cycle("run_013", 12'h013, 1, 0, 0);
    expect_cycle("run_014", 12'h014, 1, 0, 0);
    expect_cycle("at_done_addr", 12'h015, 1, 0, 0);
    jump_abs = 1; jump_target = 12'h123;
    expect_cycle("enter_done", 12'h015, 0, 1, 0);
    expect_cycle("done_ignores", 12'h015, 0, 1, 0);

    clear_req(); start = 1; start_addr = 12'h0A0; done_addr = 12'h100;
    expect_cycle("done_to_run", 12'h0A0, 1, 0, 0);
    start = 0; advance = 1;
    expect_cycle("run_0a1", 12'h0A1, 1, 0, 0);
    reset_n = 0;
    expect_cycle("reset_mid_run", 12'h000, 0, 0, 0);
    reset_n = 1;
    expect_cycle("idle_after_reset", 12'h000, 0, 0, 0);
    clear_req();

    for (int i = 0; i < 5 && q.size() != 0; i++) @(negedge clock);
    if (q.size() != 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
